load_writeback_unit: RTL and testbench
======================================

LOAD_WRITEBACK_UNIT -- requirements
Module: load_writeback_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of cycles to wait for mem_ack; used only with LOAD_TIMEOUT_EN.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  load request strobe, sampled only in IDLE.
REQ-005 funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-006 addr  input  32  byte address of the load.
REQ-007 rd  input  5  destination register index.
REQ-008 mem_req  output  1  memory read request, held until acknowledged.
REQ-009 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-010 mem_ack  input  1  memory acknowledge; mem_rdata is valid in the same cycle.
REQ-011 mem_rdata  input  32  memory read word.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse, for both success and fault.
REQ-014 fault  output  1  one-cycle pulse, coincident with done, on misaligned, illegal, or timed-out loads.
REQ-015 writeEnable  output  1  register-file write strobe.
REQ-016 writeAddr  output  5  register-file write index.
REQ-017 writeData  output  32  register-file write data.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WB and FAULT, with no other states.
REQ-019 In IDLE with start=1, the unit SHALL latch addr, funct3 and rd, then enter REQ if the load is legal, otherwise FAULT.
REQ-020 A load SHALL be illegal if funct3 is in {011,110,111}, if it is LH/LHU with addr[0]=1, or if it is LW with addr[1:0]!=0.
REQ-021 In REQ, mem_req SHALL be 1 and mem_addr stable; on mem_ack=1 the unit SHALL capture the extended data and enter WB, otherwise remain in REQ.
REQ-022 Byte and halfword selection SHALL use latched addr[1:0] (little-endian); LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-023 WB SHALL last exactly one cycle, with done=1, writeAddr=rd, writeData=extended value and writeEnable=(rd!=0), then return to IDLE.
REQ-024 FAULT SHALL last exactly one cycle, with done=1, fault=1 and writeEnable=0, issue no memory request, then return to IDLE.
REQ-025 Minimum latency: start at cycle N, mem_req at N+1, ack at N+1, writeEnable at N+2; the next start is accepted at N+3.
REQ-026 start while busy=1 SHALL be ignored with no side effects.
REQ-027 mem_ack outside REQ SHALL be ignored.
REQ-028 writeEnable SHALL be 0 in every state except WB.

Reset
REQ-029 On reset, state SHALL become IDLE and mem_req, busy, done, fault and writeEnable SHALL be 0 at the next edge.
REQ-030 On reset, mem_addr, writeAddr and writeData SHALL be 0 at the next edge.
REQ-031 Reset mid-load SHALL abandon the load with no register write; a subsequent mem_ack SHALL be ignored.

Configuration
REQ-032 With macro LOAD_TIMEOUT_EN defined, an 8-bit-or-wider counter SHALL clear on entry to REQ and increment each REQ cycle.
REQ-033 With LOAD_TIMEOUT_EN defined, after TIMEOUT_CYCLES REQ cycles without mem_ack the unit SHALL drop mem_req and enter FAULT.
REQ-034 Without LOAD_TIMEOUT_EN, no counter SHALL exist and REQ SHALL wait indefinitely.

Structure
REQ-035 Shared package load_pkg SHALL hold the funct3 load encodings and the FSM state encoding.
REQ-036 Sub-module load_extend (combinational: rdata, addr[1:0], funct3 -> 32-bit result) SHALL perform byte/halfword selection and extension.

Verification
REQ-037 LB at addr 0x103, mem_rdata 0x80FF_1234, rd=5 -> writeData 0xFFFF_FF80, writeAddr 5, writeEnable one cycle.
REQ-038 LHU at addr 0x202, mem_rdata 0xBEEF_0000, rd=7 -> writeData 0x0000_BEEF; mem_addr 0x200.
REQ-039 LW at addr 0x101 -> fault=1 and done=1 at N+1, mem_req never asserted, writeEnable 0.
REQ-040 LW with rd=0, ack delayed 3 cycles -> mem_req high 4 cycles, done pulses, writeEnable stays 0; start pulses during busy are ignored.
REQ-041 Reset asserted in REQ, then mem_ack next cycle -> no write, busy 0, IDLE accepts a new start.
REQ-042 With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 cycles and fault and done pulse together.

Source files
------------

// File: rtl/load_pkg.sv
// Shared definitions for the load/writeback unit: funct3 load encodings,
// FSM state encoding and the load legality check.
package load_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WB    = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   // A load is legal when funct3 is a known load type and the byte address
   // is naturally aligned for its access size.
   function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] addr_lo);
      logic ok;
      case (f3)
         F3_LB, F3_LBU: ok = 1'b1;
         F3_LH, F3_LHU: ok = ~addr_lo[0];
         F3_LW:         ok = (addr_lo == 2'b00);
         default:       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/halfword lane selection (little-endian) and
// sign/zero extension of a 32-bit memory word.
module load_extend
   import load_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed lane, then extend according to the load type.
   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  result = {24'd0, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  result = {16'd0, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/load_writeback_unit.sv
// Load/writeback unit: accepts a load request, reads one word from memory,
// extends the addressed lane and writes it to the register file.
// Optional feature macro: LOAD_TIMEOUT_EN (abandon a load with a fault when
// mem_ack does not arrive within TIMEOUT_CYCLES request cycles).
//
// Memory handshake: mem_req acts as valid; mem_ack acts as ready. A read
// completes in the cycle where both are high (mem_rdata valid that cycle).
// Once raised, mem_req stays high and mem_addr stays stable until that
// cycle (or until a timeout/reset abandons the request).
module load_writeback_unit
   import load_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [4:0]  rd,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic        writeEnable,
   output logic [4:0]  writeAddr,
   output logic [31:0] writeData,
   output state_t      debug_state
);

   state_t      state_q;
   state_t      state_d;
   logic [31:0] addr_q;
   logic [2:0]  funct3_q;
   logic [4:0]  rd_q;
   logic [31:0] data_q;
   logic [31:0] ext_result;
   logic        timeout_hit;

   load_extend u_extend (
      .rdata   (mem_rdata),
      .addr_lo (addr_q[1:0]),
      .funct3  (funct3_q),
      .result  (ext_result)
   );

`ifdef LOAD_TIMEOUT_EN
   localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TW-1:0] timer_q;

   // Counts request cycles; held at zero outside REQ so it starts clean on entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else if (state_q != S_REQ) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + TW'(1);
      end
   end

   // Last allowed request cycle is the TIMEOUT_CYCLES-th one.
   assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start is only looked at in IDLE, mem_ack only in REQ.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = load_legal(funct3, addr[1:0]) ? S_REQ : S_FAULT;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               state_d = S_WB;
            end else if (timeout_hit) begin
               state_d = S_FAULT;
            end
         end
         S_WB:    state_d = S_IDLE;
         S_FAULT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      mem_req     = (state_q == S_REQ);
      busy        = (state_q != S_IDLE);
      done        = (state_q == S_WB) || (state_q == S_FAULT);
      fault       = (state_q == S_FAULT);
      writeEnable = (state_q == S_WB) && (rd_q != 5'd0);
   end

   // Request fields latch on an accepted start; read data latches on the ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q   <= '0;
         funct3_q <= '0;
         rd_q     <= '0;
         data_q   <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            addr_q   <= addr;
            funct3_q <= funct3;
            rd_q     <= rd;
         end
         if (state_q == S_REQ && mem_ack) begin
            data_q <= ext_result;
         end
      end
   end

   assign mem_addr    = {addr_q[31:2], 2'b00};
   assign writeAddr   = rd_q;
   assign writeData   = data_q;
   assign debug_state = state_q;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed testbench for load_writeback_unit. Inputs change 1 ns after the
// rising edge; outputs are checked at that same point, away from the edge.
module tb_load_writeback_unit;
  import load_pkg::*;

`ifdef LOAD_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        busy;
  logic        done;
  logic        fault;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  state_t      debug_state;

  int tests_run = 0;
  int tests_failed = 0;

  load_writeback_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .funct3      (funct3),
    .addr        (addr),
    .rd          (rd),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .debug_state (debug_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r);
    start  = 1'b1;
    funct3 = f3;
    addr   = a;
    rd     = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({mem_req, busy, done, fault, writeEnable} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, busy, done, fault, writeEnable});
    end
    tests_run++;
    if ({mem_addr, writeAddr, writeData} !== 69'd0) begin
      tests_failed++;
      $display("FAIL reset_data: mem_addr=%h writeAddr=%0d writeData=%h expected all 0", mem_addr, writeAddr, writeData);
    end
    tests_run++;
    if (debug_state !== S_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", debug_state, S_IDLE);
    end
    reset = 1'b0;
  endtask

  // One legal load with a same-cycle ack: exercises minimum latency N+1/N+2/N+3.
  task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] r, input logic [31:0] rdata, input logic [31:0] exp_data);
    drive_start(f3, a, r);
    tick();
    start = 1'b0;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== {a[31:2], 2'b00} || writeEnable !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_req: mem_req=%b mem_addr=%h we=%b expected 1 %h 0", name, mem_req, mem_addr, writeEnable, {a[31:2], 2'b00});
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_0000;
    tests_run++;
    if (writeEnable !== (r != 5'd0) || writeData !== exp_data || writeAddr !== r ||
        done !== 1'b1 || fault !== 1'b0 || mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_wb: we=%b data=%h addr=%0d done=%b fault=%b req=%b expected we=%b data=%h addr=%0d done=1 fault=0 req=0",
               name, writeEnable, writeData, writeAddr, done, fault, mem_req, (r != 5'd0), exp_data, r);
    end
    tick();
    tests_run++;
    if (writeEnable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle: we=%b busy=%b done=%b expected 0 0 0", name, writeEnable, busy, done);
    end
  endtask

  task automatic test_lb();
    run_load("lb_103", F3_LB, 32'h0000_0103, 5'd5, 32'h80FF_1234, 32'hFFFF_FF80);
  endtask

  task automatic test_lhu();
    run_load("lhu_202", F3_LHU, 32'h0000_0202, 5'd7, 32'hBEEF_0000, 32'h0000_BEEF);
  endtask

  task automatic test_extend();
    logic [2:0]  f3_t[7]  = '{F3_LB, F3_LB, F3_LBU, F3_LBU, F3_LH, F3_LH, F3_LW};
    logic [31:0] a_t[7]   = '{32'h0, 32'h1, 32'h1, 32'h2, 32'h6, 32'h4, 32'h8};
    logic [31:0] rd_t[7]  = '{32'h0000_007F, 32'h0000_8000, 32'h0000_AB00, 32'h00CD_0000,
                              32'h8001_7FFF, 32'h8001_7FFF, 32'hDEAD_BEEF};
    logic [31:0] exp_t[7] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00AB, 32'h0000_00CD,
                              32'hFFFF_8001, 32'h0000_7FFF, 32'hDEAD_BEEF};
    for (int i = 0; i < 7; i++) begin
      run_load($sformatf("ext%0d", i), f3_t[i], a_t[i], 5'(i + 1), rd_t[i], exp_t[i]);
    end
  endtask

  task automatic test_faults();
    logic [2:0]  f3_t[7] = '{F3_LW, F3_LW, F3_LH, F3_LHU, 3'b011, 3'b110, 3'b111};
    logic [31:0] a_t[7]  = '{32'h101, 32'h102, 32'h001, 32'h003, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      drive_start(f3_t[i], a_t[i], 5'd9);
      tick();
      start = 1'b0;
      tests_run++;
      if (fault !== 1'b1 || done !== 1'b1 || mem_req !== 1'b0 || writeEnable !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL fault%0d: fault=%b done=%b req=%b we=%b busy=%b expected 1 1 0 0 1",
                 i, fault, done, mem_req, writeEnable, busy);
      end
      tick();
      tests_run++;
      if (fault !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL fault%0d_after: fault=%b done=%b busy=%b req=%b expected 0 0 0 0", i, fault, done, busy, mem_req);
      end
    end
  endtask

  // LW to x0 with a late ack; start pulses while busy must change nothing.
  task automatic test_back_to_back();
    int req_cycles = 0;
    drive_start(F3_LW, 32'h0000_0040, 5'd0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (mem_req === 1'b1) req_cycles++;
      tests_run++;
      if (mem_addr !== 32'h0000_0040) begin
        tests_failed++;
        $display("FAIL busy_addr%0d: got %h expected 00000040", c, mem_addr);
      end
      drive_start(F3_LB, 32'h0000_0083, 5'd9);
      mem_ack   = (c == 4);
      mem_rdata = (c == 4) ? 32'h1234_5678 : 32'h0;
      tick();
    end
    start   = 1'b0;
    mem_ack = 1'b0;
    tests_run++;
    if (req_cycles != 4 || mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL delayed_req: req_cycles=%0d req_now=%b expected 4 0", req_cycles, mem_req);
    end
    tests_run++;
    if (done !== 1'b1 || writeEnable !== 1'b0 || writeAddr !== 5'd0 || writeData !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL delayed_wb: done=%b we=%b addr=%0d data=%h expected 1 0 0 12345678", done, writeEnable, writeAddr, writeData);
    end
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || writeData !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL stray_ack: busy=%b req=%b done=%b data=%h expected 0 0 0 12345678", busy, mem_req, done, writeData);
    end
  endtask

  task automatic test_reset_mid_load();
    drive_start(F3_LW, 32'h0000_0010, 5'd3);
    tick();
    start = 1'b0;
    tests_run++;
    if (mem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_req: got %b expected 1", mem_req);
    end
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tests_run++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || writeEnable !== 1'b0 || mem_addr !== 32'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: busy=%b req=%b we=%b mem_addr=%h expected 0 0 0 0", busy, mem_req, writeEnable, mem_addr);
    end
    tick();
    mem_ack = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || writeEnable !== 1'b0 || done !== 1'b0 || writeData !== 32'd0) begin
      tests_failed++;
      $display("FAIL mid_ack_ignored: busy=%b we=%b done=%b data=%h expected 0 0 0 0", busy, writeEnable, done, writeData);
    end
    run_load("after_reset", F3_LBU, 32'h0000_0022, 5'd12, 32'h0055_0000, 32'h0000_0055);
  endtask

`ifdef LOAD_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles = 0;
    bit seen = 0;
    drive_start(F3_LW, 32'h0000_0300, 5'd4);
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (done === 1'b1) begin
        seen = 1;
        tests_run++;
        if (fault !== 1'b1 || mem_req !== 1'b0 || writeEnable !== 1'b0) begin
          tests_failed++;
          $display("FAIL timeout_fault: fault=%b req=%b we=%b expected 1 0 0", fault, mem_req, writeEnable);
        end
      end else begin
        if (mem_req === 1'b1) req_cycles++;
        tick();
      end
    end
    tests_run++;
    if (!seen || req_cycles != 4) begin
      tests_failed++;
      $display("FAIL timeout_len: done_seen=%0d req_cycles=%0d expected 1 4", seen, req_cycles);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_lb();
    test_lhu();
    test_extend();
    test_faults();
    test_back_to_back();
    test_reset_mid_load();
`ifdef LOAD_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
